// File: rtl/operand_fetch.sv
// Operand fetch stage: 8x16 register file with a two-cycle A/B read sequence
// and a valid/ready handshake toward the ALU A side and the shifter.
module operand_fetch #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned AW     = 3
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [AW-1:0]     rn_a_i,
    input  logic [AW-1:0]     rn_b_i,
    input  logic [1:0]        shift_i,
    input  logic              out_ready_i,
    input  logic              write_i,
    input  logic [AW-1:0]     writenum_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              busy_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] a_out_o,
    output logic [DATA_W-1:0] b_out_o,
    output logic [1:0]        shift_out_o
);

    localparam int unsigned SHIFT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ_A,
        S_READ_B,
        S_VALID
    } state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        rn_a_q, rn_a_d;
    logic [AW-1:0]        rn_b_q, rn_b_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]    a_q, a_d;
    logic [DATA_W-1:0]    b_q, b_d;
    logic [SHIFT_W-1:0]   shout_q, shout_d;
    logic [DATA_W-1:0]    rf_q [NREGS];
    logic [DATA_W-1:0]    rd_a, rd_b;

    // Read ports forward same-cycle write data so a concurrent write is never missed
    always_comb begin
        rd_a = rf_q[rn_a_q];
        rd_b = rf_q[rn_b_q];
        if (write_i && (writenum_i == rn_a_q)) rd_a = data_i;
        if (write_i && (writenum_i == rn_b_q)) rd_b = data_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (write_i) begin
            rf_q[writenum_i] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            rn_a_q  <= '0;
            rn_b_q  <= '0;
            shift_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            shout_q <= '0;
        end else begin
            state_q <= state_d;
            rn_a_q  <= rn_a_d;
            rn_b_q  <= rn_b_d;
            shift_q <= shift_d;
            a_q     <= a_d;
            b_q     <= b_d;
            shout_q <= shout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rn_a_d  = rn_a_q;
        rn_b_d  = rn_b_q;
        shift_d = shift_q;
        a_d     = a_q;
        b_d     = b_q;
        shout_d = shout_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    rn_a_d  = rn_a_i;
                    rn_b_d  = rn_b_i;
                    shift_d = shift_i;
                    state_d = S_READ_A;
                end
            end
            S_READ_A: begin
                a_d     = rd_a;
                state_d = S_READ_B;
            end
            S_READ_B: begin
                b_d     = rd_b;
                shout_d = shift_q;
                state_d = S_VALID;
            end
            S_VALID: begin
                // A new request is only taken together with the handshake
                if (out_ready_i) begin
                    if (start_i) begin
                        rn_a_d  = rn_a_i;
                        rn_b_d  = rn_b_i;
                        shift_d = shift_i;
                        state_d = S_READ_A;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o      = (state_q != S_IDLE);
    assign valid_o     = (state_q == S_VALID);
    assign a_out_o     = a_q;
    assign b_out_o     = b_q;
    assign shift_out_o = shout_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized
// fetches compared against a register-array reference model.
module tb_operand_fetch;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREGS  = 8;
    localparam int unsigned AW     = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [AW-1:0]     rn_a = '0;
    logic [AW-1:0]     rn_b = '0;
    logic [1:0]        shift_in = '0;
    logic              out_ready = 1'b0;
    logic              write = 1'b0;
    logic [AW-1:0]     writenum = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic              busy, valid;
    logic [DATA_W-1:0] a_out, b_out;
    logic [1:0]        shift_out;

    logic [DATA_W-1:0] mrf [NREGS];
    int checks = 0;
    int errors = 0;

    operand_fetch #(.DATA_W(DATA_W), .NREGS(NREGS), .AW(AW)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .rn_a_i(rn_a), .rn_b_i(rn_b),
        .shift_i(shift_in), .out_ready_i(out_ready), .write_i(write), .writenum_i(writenum),
        .data_i(data_in), .busy_o(busy), .valid_o(valid), .a_out_o(a_out), .b_out_o(b_out),
        .shift_out_o(shift_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Downstream shifter behaviour: pass, LSL1, LSR1, ASR1
    function automatic logic [DATA_W-1:0] shifter(input logic [DATA_W-1:0] v, input logic [1:0] sh);
        case (sh)
            2'd0:    return v;
            2'd1:    return v << 1;
            2'd2:    return v >> 1;
            default: return {v[DATA_W-1], v[DATA_W-1:1]};
        endcase
    endfunction

    // One clock edge; the model register file takes the write seen at that edge
    task automatic tick();
        @(posedge clk);
        if (!reset && write) mrf[writenum] = data_in;
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] n, input logic [DATA_W-1:0] d);
        write = 1'b1; writenum = n; data_in = d;
        tick();
        write = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic [1:0] sh);
        start = 1'b1; rn_a = ra; rn_b = rb; shift_in = sh;
        tick();
        start = 1'b0;
    endtask

    task automatic rand_write(input logic [AW-1:0] hot);
        write    = 1'($urandom_range(0, 1));
        writenum = ($urandom_range(0, 1) == 1) ? hot : AW'($urandom_range(0, NREGS-1));
        data_in  = DATA_W'($urandom);
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREGS; i++) mrf[i] = '0;
        reset = 1'b1;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (a_out !== 16'h0 || b_out !== 16'h0 || shift_out !== 2'b00) begin
            errors++; $display("FAIL reset_outputs: got a=%h b=%h sh=%b expected 0/0/00", a_out, b_out, shift_out); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        wr(3, 16'hF0CF);
        wr(5, 16'h0001);
        out_ready = 1'b0;
        issue(3, 5, 2'b01);
        checks++; if (busy !== 1'b1 || valid !== 1'b0) begin
            errors++; $display("FAIL basic_after_e0: got busy=%b valid=%b expected 1/0", busy, valid); end
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_after_e1: got valid=%b expected 0", valid); end
        tick();
        checks++; if (valid !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL basic_valid: got valid=%b busy=%b expected 1/1", valid, busy); end
        checks++; if (a_out !== 16'hF0CF || b_out !== 16'h0001 || shift_out !== 2'b01) begin
            errors++; $display("FAIL basic_data: got a=%h b=%h sh=%b expected f0cf/0001/01", a_out, b_out, shift_out); end
        checks++; if (shifter(b_out, shift_out) !== 16'h0002) begin
            errors++; $display("FAIL basic_shifter: got %h expected 0002", shifter(b_out, shift_out)); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (valid !== 1'b1 || busy !== 1'b1 || a_out !== 16'hF0CF || b_out !== 16'h0001 || shift_out !== 2'b01) begin
                errors++; $display("FAIL backpressure_hold%0d: got v=%b bz=%b a=%h b=%h sh=%b expected 1/1/f0cf/0001/01",
                                   i, valid, busy, a_out, b_out, shift_out); end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL backpressure_release: got valid=%b busy=%b expected 0/0", valid, busy); end
        checks++; if (a_out !== 16'hF0CF || b_out !== 16'h0001) begin
            errors++; $display("FAIL backpressure_keep: got a=%h b=%h expected f0cf/0001", a_out, b_out); end
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] exp_a;
        wr(2, 16'h0000);
        wr(1, DATA_W'($urandom));
        exp_a = mrf[1];
        issue(1, 2, 2'b00);
        tick();
        write = 1'b1; writenum = 3'd2; data_in = 16'hFFFF;
        tick();
        write = 1'b0;
        checks++; if (valid !== 1'b1 || a_out !== exp_a || b_out !== 16'hFFFF) begin
            errors++; $display("FAIL bypass_b: got v=%b a=%h b=%h expected 1/%h/ffff", valid, a_out, b_out, exp_a); end
        wr(2, 16'h1234);
        checks++; if (b_out !== 16'hFFFF) begin errors++; $display("FAIL bypass_late_write: got b=%h expected ffff", b_out); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        wr(4, 16'h8000);
        issue(0, 7, 2'b00);
        tick(); tick();
        checks++; if (valid !== 1'b1 || a_out !== mrf[0] || b_out !== mrf[7]) begin
            errors++; $display("FAIL b2b_first: got v=%b a=%h b=%h expected 1/%h/%h", valid, a_out, b_out, mrf[0], mrf[7]); end
        start = 1'b1; rn_a = 3'd4; rn_b = 3'd4; shift_in = 2'b11; out_ready = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        checks++; if (valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_read_a: got valid=%b busy=%b expected 0/1", valid, busy); end
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_read_b: got valid=%b expected 0", valid); end
        tick();
        checks++; if (valid !== 1'b1 || a_out !== 16'h8000 || b_out !== 16'h8000 || shift_out !== 2'b11) begin
            errors++; $display("FAIL b2b_second: got v=%b a=%h b=%h sh=%b expected 1/8000/8000/11", valid, a_out, b_out, shift_out); end
        checks++; if (shifter(b_out, shift_out) !== 16'hC000) begin
            errors++; $display("FAIL b2b_shifter: got %h expected c000", shifter(b_out, shift_out)); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_ignored_start();
        logic [DATA_W-1:0] ea, eb;
        wr(6, 16'h5A5A);
        wr(0, 16'h1111);
        wr(1, 16'h2222);
        ea = mrf[6]; eb = mrf[7];
        issue(6, 7, 2'b10);
        start = 1'b1; rn_a = 3'd0; rn_b = 3'd1; shift_in = 2'b01;
        tick(); tick();
        start = 1'b0;
        checks++; if (valid !== 1'b1 || a_out !== ea || b_out !== eb || shift_out !== 2'b10) begin
            errors++; $display("FAIL ignored_start_data: got v=%b a=%h b=%h sh=%b expected 1/%h/%h/10", valid, a_out, b_out, shift_out, ea, eb); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL ignored_start_extra%0d: got valid=%b busy=%b expected 0/0", i, valid, busy); end
        end
    endtask

    task automatic test_reset_mid();
        wr(3, 16'hABCD);
        issue(3, 3, 2'b11);
        tick();
        reset = 1'b1;
        #1;
        checks++; if (valid !== 1'b0 || busy !== 1'b0 || a_out !== 16'h0 || b_out !== 16'h0 || shift_out !== 2'b00) begin
            errors++; $display("FAIL reset_mid_async: got v=%b bz=%b a=%h b=%h sh=%b expected 0/0/0/0/00", valid, busy, a_out, b_out, shift_out); end
        for (int i = 0; i < NREGS; i++) mrf[i] = '0;
        tick();
        reset = 1'b0;
        tick();
        out_ready = 1'b0;
        issue(3, 5, 2'b01);
        tick(); tick();
        checks++; if (valid !== 1'b1 || a_out !== 16'h0 || b_out !== 16'h0 || shift_out !== 2'b01) begin
            errors++; $display("FAIL reset_mid_cleared: got v=%b a=%h b=%h sh=%b expected 1/0/0/01", valid, a_out, b_out, shift_out); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [AW-1:0] ra, rb;
        logic [1:0] sh;
        logic [DATA_W-1:0] ea, eb;
        for (int n = 0; n < 40; n++) begin
            ra = AW'($urandom_range(0, NREGS-1));
            rb = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, NREGS-1));
            sh = 2'($urandom_range(0, 3));
            start = 1'b1; rn_a = ra; rn_b = rb; shift_in = sh; out_ready = 1'b1;
            rand_write(ra);
            tick();
            out_ready = 1'b0;
            start = 1'($urandom_range(0, 1));
            rn_a = AW'($urandom); rn_b = AW'($urandom); shift_in = 2'($urandom);
            rand_write(ra);
            tick();
            ea = mrf[ra];
            rand_write(rb);
            tick();
            eb = mrf[rb];
            start = 1'b0; write = 1'b0;
            checks++; if (valid !== 1'b1 || a_out !== ea || b_out !== eb || shift_out !== sh) begin
                errors++; $display("FAIL random%0d_fetch: got v=%b a=%h b=%h sh=%b expected 1/%h/%h/%b", n, valid, a_out, b_out, shift_out, ea, eb, sh); end
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                rand_write(rb);
                tick();
                write = 1'b0;
                checks++; if (valid !== 1'b1 || a_out !== ea || b_out !== eb || shift_out !== sh) begin
                    errors++; $display("FAIL random%0d_hold: got v=%b a=%h b=%h expected 1/%h/%h", n, valid, a_out, b_out, ea, eb); end
            end
            if ($urandom_range(0, 1) == 1) begin
                out_ready = 1'b1;
                tick();
                out_ready = 1'b0;
                checks++; if (valid !== 1'b0 || busy !== 1'b0 || a_out !== ea || b_out !== eb) begin
                    errors++; $display("FAIL random%0d_idle: got v=%b bz=%b a=%h b=%h expected 0/0/%h/%h", n, valid, busy, a_out, b_out, ea, eb); end
            end
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL random_final_idle: got valid=%b busy=%b expected 0/0", valid, busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_bypass();
        test_back_to_back();
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
